rsa_request_sequencer: RTL and testbench

Host-side initiator for the RSA `control` core.
- Accepts encrypt/decrypt requests on a valid/ready interface.
- Drives `control`'s primes, mode, message and both reset lines (`reset` for the inverter, `reset1` for mod-exp).
- Waits for `mod_exp_finish`, then returns `msg_out` on a valid/ready response interface.
- Caches the last key pair so inverter key generation is skipped when p and q are unchanged.

---
 rtl/rsa_seq_pkg.sv | 41 ++++
 rtl/seq_cycle_counter.sv | 35 +++
 rtl/rsa_request_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_rsa_request_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_seq_pkg.sv
`timescale 1ns/1ps
// rsa_seq_pkg
// Shared definitions for the RSA request sequencer: default parameter values,
// the sequencer state encoding and the width helper for the shared
// down-counter.
package rsa_seq_pkg;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_KEY_CYCLES = 512;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 65536;

  // Fixed state codes so external checkers and older tooling can decode the
  // state register without the enum type.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEY_RST  = 3'd1;
  localparam logic [2:0] S_KEY_WAIT = 3'd2;
  localparam logic [2:0] S_EXP_RST  = 3'd3;
  localparam logic [2:0] S_EXP_RUN  = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_KEY_RST  = S_KEY_RST,
    ST_KEY_WAIT = S_KEY_WAIT,
    ST_EXP_RST  = S_EXP_RST,
    ST_EXP_RUN  = S_EXP_RUN,
    ST_RESP     = S_RESP
  } seq_state_e;

  // Counter must hold the largest phase length it is ever loaded for.
  function automatic int cnt_width(input int key_cycles, input int timeout,
                                   input int rst_cycles);
    int m;
    m = key_cycles;
    if (timeout > m) m = timeout;
    if (rst_cycles > m) m = rst_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
`timescale 1ns/1ps
// seq_cycle_counter
// Loadable down-counter that saturates at zero (never wraps).
// Ports:
//   clk, reset  - clock, synchronous active-high reset (count -> 0)
//   load        - load load_val this cycle (has priority over en)
//   load_val    - value to load
//   en          - decrement when non-zero
//   count       - current count
//   zero        - count == 0
module seq_cycle_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rsa_request_sequencer.sv
`timescale 1ns/1ps
// rsa_request_sequencer
// Host-side initiator for the RSA control core. Accepts one encrypt/decrypt
// request at a time, sequences the inverter (key generation) and mod-exp
// resets, waits for mod_exp_finish and returns msg_out as a response.
// Key generation is skipped when p and q match the last generated pair.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may depend combinationally on state but never on valid.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req_valid/req_ready        - request handshake
//   req_p, req_q               - primes (WIDTH)
//   req_enc                    - 1 = encrypt, 0 = decrypt
//   req_msg                    - message or cipher (2*WIDTH)
//   rsp_valid/rsp_ready        - response handshake
//   rsp_data                   - result (2*WIDTH), 0 on timeout
//   rsp_timeout                - response is a timeout error
//   busy                       - sequencer not idle
//   ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in - to control core
//   ctl_reset                  - inverter reset, high only in KEY_RST/reset
//   ctl_reset1                 - mod-exp reset, low only in EXP_RUN
//   ctl_mod_exp_finish         - from control core
//   ctl_msg_out                - from control core
module rsa_request_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int KEY_CYCLES = DEF_KEY_CYCLES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_p,
  input  logic [WIDTH-1:0]   req_q,
  input  logic               req_enc,
  input  logic [2*WIDTH-1:0] req_msg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_timeout,
  output logic               busy,
  output logic [WIDTH-1:0]   ctl_p,
  output logic [WIDTH-1:0]   ctl_q,
  output logic               ctl_encrypt_decrypt,
  output logic [2*WIDTH-1:0] ctl_msg_in,
  output logic               ctl_reset,
  output logic               ctl_reset1,
  input  logic               ctl_mod_exp_finish,
  input  logic [2*WIDTH-1:0] ctl_msg_out
);

  localparam int CW = cnt_width(KEY_CYCLES, TIMEOUT, RST_CYCLES);

  // Each phase lasts N cycles: loaded with N-1 on entry, left when zero.
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] KEY_LOAD = CW'(KEY_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT - 1);

  seq_state_e       state;
  seq_state_e       state_nx;
  logic             key_valid;
  logic [WIDTH-1:0] cached_p;
  logic [WIDTH-1:0] cached_q;

  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;

  logic             accept;
  logic             key_hit;
  logic             first_run;
  logic             finish_seen;

  seq_cycle_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (1'b1),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign req_ready = (state == ST_IDLE) && !reset;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign key_hit   = key_valid && (req_p == cached_p) && (req_q == cached_q);

  // The counter still holds its entry value only in the first EXP_RUN cycle;
  // a finish seen there is left over from the previous operation.
  assign first_run   = (cnt == TO_LOAD);
  assign finish_seen = ctl_mod_exp_finish && !first_run;

  // Inverter keeps its keys outside KEY_RST; mod-exp is parked outside EXP_RUN.
  assign ctl_reset  = reset || (state == ST_KEY_RST);
  assign ctl_reset1 = reset || (state != ST_EXP_RUN);

  always_comb begin
    state_nx     = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx     = key_hit ? ST_EXP_RST : ST_KEY_RST;
          cnt_load     = 1'b1;
          cnt_load_val = RST_LOAD;
        end
      end
      ST_KEY_RST: begin
        if (cnt_zero) begin
          state_nx     = ST_KEY_WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = KEY_LOAD;
        end
      end
      ST_KEY_WAIT: begin
        if (cnt_zero) begin
          state_nx     = ST_EXP_RST;
          cnt_load     = 1'b1;
          cnt_load_val = RST_LOAD;
        end
      end
      ST_EXP_RST: begin
        if (cnt_zero) begin
          state_nx     = ST_EXP_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = TO_LOAD;
        end
      end
      ST_EXP_RUN: begin
        if (finish_seen || cnt_zero) begin
          state_nx = ST_RESP;
          cnt_load = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
          cnt_load = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      key_valid           <= 1'b0;
      cached_p            <= '0;
      cached_q            <= '0;
      ctl_p               <= '0;
      ctl_q               <= '0;
      ctl_encrypt_decrypt <= 1'b0;
      ctl_msg_in          <= '0;
      rsp_data            <= '0;
      rsp_timeout         <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ctl_p               <= req_p;
        ctl_q               <= req_q;
        ctl_encrypt_decrypt <= req_enc;
        ctl_msg_in          <= req_msg;
      end
      if ((state == ST_KEY_WAIT) && cnt_zero) begin
        key_valid <= 1'b1;
        cached_p  <= ctl_p;
        cached_q  <= ctl_q;
      end
      if (state == ST_EXP_RUN) begin
        // Finish has priority over a timeout expiring in the same cycle.
        if (finish_seen) begin
          rsp_data    <= ctl_msg_out;
          rsp_timeout <= 1'b0;
        end else if (cnt_zero) begin
          rsp_data    <= '0;
          rsp_timeout <= 1'b1;
          // The core may be wedged; force a fresh key generation next time.
          key_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rsa_request_sequencer.sv
`timescale 1ns/1ps
module tb_rsa_request_sequencer;

  localparam int W  = 8;
  localparam int DW = 2 * W;
  localparam int KC = 16;
  localparam int RC = 2;
  localparam int TO = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_p = '0;
  logic [W-1:0]  req_q = '0;
  logic          req_enc = 1'b0;
  logic [DW-1:0] req_msg = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          busy;
  logic [W-1:0]  ctl_p;
  logic [W-1:0]  ctl_q;
  logic          ctl_encrypt_decrypt;
  logic [DW-1:0] ctl_msg_in;
  logic          ctl_reset;
  logic          ctl_reset1;
  logic          ctl_mod_exp_finish;
  logic [DW-1:0] ctl_msg_out;

  rsa_request_sequencer #(
    .WIDTH(W), .KEY_CYCLES(KC), .RST_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q), .req_enc(req_enc), .req_msg(req_msg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
    .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_encrypt_decrypt(ctl_encrypt_decrypt),
    .ctl_msg_in(ctl_msg_in), .ctl_reset(ctl_reset), .ctl_reset1(ctl_reset1),
    .ctl_mod_exp_finish(ctl_mod_exp_finish), .ctl_msg_out(ctl_msg_out)
  );

  // ---------------- counters / helpers ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint gcd(input longint a, input longint b);
    longint t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic longint modexp(input longint b, input longint e, input longint n);
    longint r;
    r = 1;
    b = b % n;
    while (e > 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  // Textbook RSA: smallest odd e coprime to phi, d its inverse mod phi.
  function automatic logic [DW-1:0] rsa_exp(input logic [W-1:0] p, input logic [W-1:0] q,
                                            input logic enc, input logic [DW-1:0] msg);
    longint n, phi, e, d;
    n = longint'(p) * longint'(q);
    phi = (longint'(p) - 1) * (longint'(q) - 1);
    if (n < 2 || phi < 2) return '0;
    e = 3;
    while (gcd(e, phi) != 1) e += 2;
    d = 1;
    while (((e * d) % phi) != 1 && d < phi) d++;
    return DW'(modexp(longint'(msg), enc ? e : d, n));
  endfunction

  // ---------------- stub control core ----------------
  // mode 0: finishes after tx_f mod-exp cycles with tx_val.
  // mode 2: computes real RSA with the keys latched during its inverter reset.
  int            tx_f = 1000000;
  logic [DW-1:0] tx_val = '0;
  int            stub_mode = 0;
  int            run_cnt = 0;
  logic [W-1:0]  k_p = '0;
  logic [W-1:0]  k_q = '0;

  always @(posedge clk) begin
    if (ctl_reset1) run_cnt <= 0;
    else            run_cnt <= run_cnt + 1;
    if (ctl_reset) begin
      k_p <= ctl_p;
      k_q <= ctl_q;
    end
  end

  assign ctl_mod_exp_finish = (run_cnt + 1 >= tx_f);

  always @* begin
    if (stub_mode == 2) ctl_msg_out = rsa_exp(k_p, k_q, ctl_encrypt_decrypt, ctl_msg_in);
    else                ctl_msg_out = tx_val;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  bit            m_kv = 1'b0;
  logic [W-1:0]  m_p = '0;
  logic [W-1:0]  m_q = '0;
  bit            in_flight = 1'b0;
  bit            after_rst = 1'b0;
  int            acc_cyc = 0;
  bit            e_keygen, e_to;
  int            e_fe;
  logic [W-1:0]  e_p, e_q;
  logic          e_enc;
  logic [DW-1:0] e_msg;
  int            rst_hi_cnt = 0;

  always @(negedge clk) begin
    int k, base, rs, re;
    cyc++;
    if (reset) begin
      check("rst_ctl_reset", ctl_reset, 1);
      check("rst_ctl_reset1", ctl_reset1, 1);
      check("rst_req_ready", req_ready, 0);
      in_flight = 1'b0;
      m_kv = 1'b0;
      after_rst = 1'b1;
      exp_q.delete();
    end else begin
      if (after_rst) begin
        check("post_rst_busy", busy, 0);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_rsp_data", rsp_data, 0);
        check("post_rst_rsp_timeout", rsp_timeout, 0);
        check("post_rst_ctl_p", ctl_p, 0);
        check("post_rst_ctl_q", ctl_q, 0);
        check("post_rst_ctl_msg_in", ctl_msg_in, 0);
        check("post_rst_ctl_enc", ctl_encrypt_decrypt, 0);
        after_rst = 1'b0;
      end
      if (!in_flight) begin
        check("idle_req_ready", req_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_ctl_reset", ctl_reset, 0);
        check("idle_ctl_reset1", ctl_reset1, 1);
        if (req_valid) begin
          acc_cyc  = cyc;
          e_p      = req_p;
          e_q      = req_q;
          e_enc    = req_enc;
          e_msg    = req_msg;
          e_keygen = !(m_kv && req_p == m_p && req_q == m_q);
          e_to     = (tx_f > TO);
          e_fe     = e_to ? TO : ((tx_f < 2) ? 2 : tx_f);
          if (e_to)                exp_q.push_back('0);
          else if (stub_mode == 2) exp_q.push_back(rsa_exp(req_p, req_q, req_enc, req_msg));
          else                     exp_q.push_back(tx_val);
          m_kv = !e_to;
          m_p = req_p;
          m_q = req_q;
          rst_hi_cnt = 0;
          in_flight = 1'b1;
        end
      end else begin
        k    = cyc - acc_cyc;
        base = e_keygen ? RC + KC : 0;
        rs   = base + RC + 1;
        re   = base + RC + e_fe;
        check("busy", busy, 1);
        check("req_ready_busy", req_ready, 0);
        check("ctl_reset", ctl_reset, 32'(e_keygen && k <= RC));
        check("ctl_reset1", ctl_reset1, 32'(!(k >= rs && k <= re)));
        check("rsp_valid", rsp_valid, 32'(k > re));
        check("ctl_p", ctl_p, e_p);
        check("ctl_q", ctl_q, e_q);
        check("ctl_enc", ctl_encrypt_decrypt, e_enc);
        check("ctl_msg_in", ctl_msg_in, e_msg);
        if (ctl_reset) rst_hi_cnt++;
        if (k > re) begin
          check("rsp_data", rsp_data, exp_q[0]);
          check("rsp_timeout", rsp_timeout, e_to);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            in_flight = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present_req(input logic [W-1:0] p, input logic [W-1:0] q,
                             input logic enc, input logic [DW-1:0] msg,
                             input int f, input logic [DW-1:0] val);
    @(posedge clk); #2;
    tx_f = f;
    tx_val = val;
    req_p = p;
    req_q = q;
    req_enc = enc;
    req_msg = msg;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk); #1;
      if (req_ready && req_valid) done = 1'b1;
      n++;
    end
    if (!done) check("accept_timeout", 0, 1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_p = W'($urandom);
    req_q = W'($urandom);
    req_enc = 1'($urandom);
    req_msg = DW'($urandom);
  endtask

  task automatic wait_rsp(output logic [DW-1:0] d, output logic t, output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!rsp_valid && n < 2000);
    if (!rsp_valid) check("rsp_wait_timeout", 0, 1);
    d = rsp_data;
    t = rsp_timeout;
    lat = cyc - acc_cyc;
  endtask

  task automatic release_rsp(input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
  endtask

  task automatic run_tx(input logic [W-1:0] p, input logic [W-1:0] q, input logic enc,
                        input logic [DW-1:0] msg, input int f, input logic [DW-1:0] val,
                        input int hold, output logic [DW-1:0] d, output logic t,
                        output int lat);
    present_req(p, q, enc, msg, f, val);
    wait_accept();
    wait_rsp(d, t, lat);
    release_rsp(hold);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic          t;
    int            lat;
    int            r, f;

    // Reset held for 3 cycles, then req_ready must come up.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check("t1_req_ready_after_rst", req_ready, 1);

    // First request generates keys.
    run_tx(8'd11, 8'd13, 1'b1, 16'd42, 10, 16'h005A, 0, d, t, lat);
    check("t2_latency", lat, 31);
    check("t2_data", d, 16'h005A);
    check("t2_timeout", t, 0);
    check("t2_ctl_reset_cycles", rst_hi_cnt, 2);

    // Same primes: key generation is skipped.
    run_tx(8'd11, 8'd13, 1'b1, 16'd7, 10, 16'h005A, 0, d, t, lat);
    check("t3_latency", lat, 13);
    check("t3_ctl_reset_cycles", rst_hi_cnt, 0);

    // Response back-pressure with a new request already waiting.
    present_req(8'd11, 8'd13, 1'b0, 16'd99, 10, 16'h005A);
    wait_accept();
    wait_rsp(d, t, lat);
    check("t4_data", d, 16'h005A);
    present_req(8'd11, 8'd13, 1'b1, 16'd5, 8, 16'h0033);
    release_rsp(5);
    wait_accept();
    wait_rsp(d, t, lat);
    check("t4_next_data", d, 16'h0033);
    check("t4_next_latency", lat, 11);
    release_rsp(0);

    // Core never finishes: timeout, then keys must be regenerated.
    run_tx(8'd11, 8'd13, 1'b1, 16'd3, 1000000, 16'h1111, 1, d, t, lat);
    check("t5_timeout_flag", t, 1);
    check("t5_timeout_data", d, 0);
    check("t5_timeout_latency", lat, 203);
    run_tx(8'd11, 8'd13, 1'b1, 16'd3, 5, 16'h2222, 0, d, t, lat);
    check("t5_regen_ctl_reset_cycles", rst_hi_cnt, 2);
    check("t5_regen_latency", lat, 26);

    // Stale finish already high: ignored in the first mod-exp cycle.
    run_tx(8'd11, 8'd13, 1'b0, 16'd8, 1, 16'h0BEE, 0, d, t, lat);
    check("stale_finish_latency", lat, 5);
    // Finish exactly at the timeout cycle: finish wins.
    run_tx(8'd11, 8'd13, 1'b0, 16'd8, TO, 16'h0C0D, 0, d, t, lat);
    check("finish_at_timeout_flag", t, 0);
    check("finish_at_timeout_data", d, 16'h0C0D);
    check("finish_at_timeout_latency", lat, 203);

    // RSA round trip through a behavioural core.
    stub_mode = 2;
    run_tx(8'd11, 8'd13, 1'b1, 16'd42, 12, 16'h0, 0, d, t, lat);
    check("t6_cipher", d, 16'd81);
    run_tx(8'd11, 8'd13, 1'b0, d, 12, 16'h0, 0, d, t, lat);
    check("t6_plain", d, 16'd42);

    // Reset in the middle of EXP_RUN drops the operation and the key cache.
    present_req(8'd11, 8'd13, 1'b1, 16'd42, 60, 16'h0);
    wait_accept();
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_ready", req_ready, 1);
    run_tx(8'd11, 8'd13, 1'b1, 16'd42, 12, 16'h0, 0, d, t, lat);
    check("t6_regen_ctl_reset_cycles", rst_hi_cnt, 2);
    check("t6_regen_cipher", d, 16'd81);

    // Randomized traffic in stub mode.
    stub_mode = 0;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      f = TO + 1 + $urandom_range(0, 50);
      else if (r == 1) f = TO;
      else             f = $urandom_range(1, 25);
      run_tx((($urandom_range(0, 2) == 0) ? 8'd17 : 8'd11),
             (($urandom_range(0, 1) == 0) ? 8'd13 : 8'd19),
             1'($urandom), DW'($urandom), f, DW'($urandom),
             $urandom_range(0, 4), d, t, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
